// File: rtl/pixel_blend_writer_pkg.sv
// Shared frame geometry, pixel/entry types and write-FSM encoding for pixel_blend_writer.
// Latency: none (types and constants only).
// Backpressure: n/a.
package pixel_blend_writer_pkg;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int ADDR_W  = 19;

  // Address of the bottom-right pixel; its write completion marks end of frame.
  localparam logic [ADDR_W-1:0] LAST_ADDR = 19'(FRAME_W * FRAME_H - 1);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    rgb565_t           data;
  } wr_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/pixel_blend_writer_fifo.sv
// Small circular FIFO (blend_wr_fifo) holding pending frame-buffer writes; head is always readable.
// Latency: push visible at head one cycle later; pop takes effect on the clock edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module blend_wr_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk_25,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage and pointer/count update; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_blend_writer.sv
// Alpha-blends DVI and CCD RGB565 pixels and queues frame-buffer writes; CHROMA_KEY_EN enables keyed pass-through.
// Latency: val at cycle n -> wr_req at n+3 (two pipeline stages, then FIFO push).
// Backpressure: wr_ack pops the 4-entry FIFO; a push into a full FIFO without pop drops the pixel and sets sticky overflow.
module pixel_blend_writer
  import pixel_blend_writer_pkg::*;
#(
  parameter logic [4:0]  ALPHA   = 5'd8,
  parameter logic [15:0] KEY_RGB = 16'h07E0
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              val,
  input  logic [9:0]        sync_x,
  input  logic [9:0]        sync_y,
  input  logic [4:0]        dvi_r,
  input  logic [5:0]        dvi_g,
  input  logic [4:0]        dvi_b,
  input  logic [4:0]        ccd_r,
  input  logic [5:0]        ccd_g,
  input  logic [4:0]        ccd_b,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ack,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [4:0] W_DVI = 5'd16 - ALPHA;

`ifdef CHROMA_KEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  // Stage 1 registers
  logic        s1_vld;
  logic [9:0]  s1_x, s1_y;
  logic [8:0]  s1_pd_r, s1_pc_r, s1_pd_b, s1_pc_b;
  logic [9:0]  s1_pd_g, s1_pc_g;
  logic        s1_key;
  rgb565_t     s1_dvi;

  // Stage 2 registers
  logic        s2_vld;
  wr_entry_t   s2_entry;

  // Stage 2 combinational results
  logic [8:0]        sum_r, sum_b;
  logic [9:0]        sum_g;
  rgb565_t           blend_pix;
  logic [ADDR_W-1:0] lin_addr;

  // FIFO / FSM
  wr_entry_t  head;
  logic       fifo_full, fifo_empty;
  logic [2:0] fifo_count;
  logic       pop_en;
  wr_state_t  state;

  logic in_range;
  assign in_range = (sync_x < 10'(FRAME_W)) && (sync_y < 10'(FRAME_H));

  // Stage 1: weight each channel and drop off-screen pixels before they reach the pipeline.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_pd_r <= '0;
      s1_pc_r <= '0;
      s1_pd_g <= '0;
      s1_pc_g <= '0;
      s1_pd_b <= '0;
      s1_pc_b <= '0;
      s1_key  <= 1'b0;
      s1_dvi  <= '0;
    end else begin
      s1_vld  <= val && in_range;
      s1_x    <= sync_x;
      s1_y    <= sync_y;
      s1_pd_r <= {4'd0, dvi_r} * {4'd0, W_DVI};
      s1_pc_r <= {4'd0, ccd_r} * {4'd0, ALPHA};
      s1_pd_g <= {4'd0, dvi_g} * {5'd0, W_DVI};
      s1_pc_g <= {4'd0, ccd_g} * {5'd0, ALPHA};
      s1_pd_b <= {4'd0, dvi_b} * {4'd0, W_DVI};
      s1_pc_b <= {4'd0, ccd_b} * {4'd0, ALPHA};
      s1_key  <= ({ccd_r, ccd_g, ccd_b} == KEY_RGB);
      s1_dvi  <= '{r: dvi_r, g: dvi_g, b: dvi_b};
    end
  end

  // Weights sum to 16, so the truncated sums always fit the channel widths.
  always_comb begin
    sum_r       = s1_pd_r + s1_pc_r;
    sum_g       = s1_pd_g + s1_pc_g;
    sum_b       = s1_pd_b + s1_pc_b;
    blend_pix.r = sum_r[8:4];
    blend_pix.g = sum_g[9:4];
    blend_pix.b = sum_b[8:4];
    lin_addr    = ({9'd0, s1_y} << 9) + ({9'd0, s1_y} << 7) + {9'd0, s1_x};
  end

  // Stage 2: register the blended (or keyed pass-through) pixel and its linear address.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_vld        <= s1_vld;
      s2_entry.addr <= lin_addr;
      s2_entry.data <= (KEY_EN && s1_key) ? s1_dvi : blend_pix;
    end
  end

  assign pop_en = (state == S_REQ) && wr_ack;

  blend_wr_fifo #(
    .W     ($bits(wr_entry_t)),
    .DEPTH (4)
  ) u_fifo (
    .clk_25   (clk_25),
    .rst_n    (rst_n),
    .push     (s2_vld),
    .push_dat (s2_entry),
    .pop      (pop_en),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign wr_addr = head.addr;
  assign wr_data = head.data;

  // Write FSM: entering S_REQ on the push edge lets wr_req rise in the same cycle the entry lands.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_req     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pop_en && (head.addr == LAST_ADDR);
      if (s2_vld && fifo_full && !pop_en) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!fifo_empty || s2_vld) begin
            state  <= S_REQ;
            wr_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (wr_ack && !(fifo_count > 3'd1 || s2_vld)) begin
            state  <= S_IDLE;
            wr_req <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_blend_writer.sv
// Directed and randomized bench for pixel_blend_writer with a queue-based reference model.
// Writes are checked in order against expected {addr,data} computed from plain blend arithmetic.
module tb_pixel_blend_writer;

  localparam int          ALPHA = 8;
  localparam logic [15:0] KEY   = 16'h07E0;

  logic        clk_25;
  logic        rst_n;
  logic        val;
  logic [9:0]  sync_x, sync_y;
  logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b;
  logic [5:0]  dvi_g, ccd_g;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        frame_done;
  logic        overflow;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [34:0] exp_q [$];

  pixel_blend_writer #(
    .ALPHA   (5'd8),
    .KEY_RGB (KEY)
  ) dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .val        (val),
    .sync_x     (sync_x),
    .sync_y     (sync_y),
    .dvi_r      (dvi_r),
    .dvi_g      (dvi_g),
    .dvi_b      (dvi_b),
    .ccd_r      (ccd_r),
    .ccd_g      (ccd_g),
    .ccd_b      (ccd_b),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  function automatic logic [15:0] model_pix(logic [15:0] d, logic [15:0] c);
    int r, g, b;
`ifdef CHROMA_KEY_EN
    if (c == KEY) return d;
`endif
    r = (int'(d[15:11]) * (16 - ALPHA) + int'(c[15:11]) * ALPHA) / 16;
    g = (int'(d[10:5])  * (16 - ALPHA) + int'(c[10:5])  * ALPHA) / 16;
    b = (int'(d[4:0])   * (16 - ALPHA) + int'(c[4:0])   * ALPHA) / 16;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic step(int k = 1);
    repeat (k) begin
      @(posedge clk_25);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel for the coming edge; optionally record the write the model expects.
  task automatic put_pix(int x, int y, logic [15:0] d, logic [15:0] c, bit expect_it);
    int a;
    val    = 1'b1;
    sync_x = 10'(x);
    sync_y = 10'(y);
    {dvi_r, dvi_g, dvi_b} = d;
    {ccd_r, ccd_g, ccd_b} = c;
    if (expect_it && x < 640 && y < 480) begin
      a = y * 640 + x;
      exp_q.push_back({a[18:0], model_pix(d, c)});
    end
  endtask

  // Every accepted write must match the oldest expected entry.
  always @(negedge clk_25) begin
    logic [34:0] e;
    if (rst_n && wr_req && wr_ack) begin
      n_asserts++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected: observed write addr %0d expected none", wr_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_asserts++;
        assert ({wr_addr, wr_data} === e) else begin
          n_fail++;
          $error("FAIL wr_entry: observed addr %0d data %0h expected addr %0d data %0h",
                 wr_addr, wr_data, e[34:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    int x, y;
    rst_n  = 1'b0;
    val    = 1'b0;
    sync_x = '0;
    sync_y = '0;
    {dvi_r, dvi_g, dvi_b} = '0;
    {ccd_r, ccd_g, ccd_b} = '0;
    wr_ack = 1'b0;

    // Reset state
    step(3);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    step(2);

    // Single pixel latency and blend value
    wr_ack = 1'b1;
    put_pix(2, 1, 16'hFFFF, 16'h0000, 1'b1);
    step(); val = 1'b0;
    chk("lat_n1_wr_req", 32'(wr_req), 0);
    step();
    chk("lat_n2_wr_req", 32'(wr_req), 0);
    step();
    chk("lat_n3_wr_req", 32'(wr_req), 1);
    chk("lat_n3_wr_addr", 32'(wr_addr), 642);
    chk("lat_n3_wr_data", 32'(wr_data), 32'h7BEF);
    step();
    chk("lat_n4_wr_req", 32'(wr_req), 0);

    // Off-screen pixels are discarded
    put_pix(640, 0, 16'hABCD, 16'h1234, 1'b1);
    step();
    put_pix(0, 480, 16'hABCD, 16'h1234, 1'b1);
    step(); val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("offscreen_wr_req", 32'(wr_req), 0);
      step();
    end
    chk("offscreen_overflow", 32'(overflow), 0);

    // Back-to-back throughput: queue must drain one per cycle
    for (int i = 0; i < 8; i++) begin
      put_pix(100 + i, 7, 16'($urandom), 16'($urandom), 1'b1);
      step();
    end
    val = 1'b0;
    step(3);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_wr_req", 32'(wr_req), 0);

    // FIFO fill with no acks: four kept, two dropped
    wr_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put_pix(10 + i, 5, 16'($urandom), 16'($urandom), i < 4);
      step();
    end
    val = 1'b0;
    step(6);
    chk("full_overflow", 32'(overflow), 1);
    chk("full_wr_req", 32'(wr_req), 1);
    chk("full_head_addr", 32'(wr_addr), 5 * 640 + 10);
    chk("full_pending", exp_q.size(), 4);
    wr_ack = 1'b1;
    step(5);
    chk("full_drained", exp_q.size(), 0);
    chk("full_idle", 32'(wr_req), 0);
    chk("full_overflow_sticky", 32'(overflow), 1);

    // Last pixel of frame and frame_done pulse
    put_pix(639, 479, 16'h5555, 16'hAAAA, 1'b1);
    step(); val = 1'b0;
    step(2);
    chk("frame_wr_addr", 32'(wr_addr), 307199);
    chk("frame_done_early", 32'(frame_done), 0);
    step();
    chk("frame_done_pulse", 32'(frame_done), 1);
    step();
    chk("frame_done_single", 32'(frame_done), 0);

    // Chroma key behaviour
    put_pix(3, 3, 16'h1234, 16'h07E0, 1'b1);
    step(); val = 1'b0;
    step(2);
`ifdef CHROMA_KEY_EN
    chk("chroma_wr_data", 32'(wr_data), 32'h1234);
`else
    chk("chroma_wr_data", 32'(wr_data), 32'h0D0A);
`endif
    step(2);

    // Reset with three queued entries
    wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put_pix(20 + i, 9, 16'($urandom), 16'($urandom), 1'b1);
      step();
    end
    val = 1'b0;
    step(4);
    chk("prerst_wr_req", 32'(wr_req), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_req", 32'(wr_req), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    exp_q.delete();
    wr_ack = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("postrst_wr_req", 32'(wr_req), 0);

    // First pixel after reset keeps the same latency
    put_pix(5, 2, 16'hF800, 16'h001F, 1'b1);
    step(); val = 1'b0;
    chk("postrst_n1", 32'(wr_req), 0);
    step();
    chk("postrst_n2", 32'(wr_req), 0);
    step();
    chk("postrst_n3", 32'(wr_req), 1);
    chk("postrst_addr", 32'(wr_addr), 2 * 640 + 5);
    step(2);

    // Randomized traffic with random gaps and near-edge coordinates
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = ($urandom_range(0, 3) == 0) ? 636 + $urandom_range(0, 6) : $urandom_range(0, 639);
        y = ($urandom_range(0, 3) == 0) ? 477 + $urandom_range(0, 5) : $urandom_range(0, 479);
        put_pix(x, y, 16'($urandom), 16'($urandom), 1'b1);
      end else begin
        val = 1'b0;
      end
      step();
    end
    val = 1'b0;
    step(8);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_overflow", 32'(overflow), 0);
    chk("rand_idle", 32'(wr_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_blend_writer.md
PIXEL_BLEND_WRITER -- requirements
Module: pixel_blend_writer

Interface
REQ-001 Parameter ALPHA, default 5'd8, CCD weight in sixteenths, legal 0..16 (0 = DVI only, 16 = CCD only).
REQ-002 Parameter KEY_RGB, default 16'h07E0, RGB565 CCD colour treated as transparent (used only under REQ-030).
REQ-003 clk_25  in  1  pixel clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 val  in  1  input pixel valid, single-cycle qualifier.
REQ-006 sync_x / sync_y  in  10 each  pixel coordinate.
REQ-007 dvi_r/dvi_g/dvi_b  in  5/6/5  DVI pixel, RGB565.
REQ-008 ccd_r/ccd_g/ccd_b  in  5/6/5  CCD pixel, RGB565.
REQ-009 wr_req  out  1  frame-buffer write request.
REQ-010 wr_addr  out  19  linear address y*640+x.
REQ-011 wr_data  out  16  blended RGB565 {r,g,b}.
REQ-012 wr_ack  in  1  write accepted this cycle.
REQ-013 frame_done  out  1  one-cycle pulse when pixel (639,479) is accepted.
REQ-014 overflow  out  1  sticky, pixel dropped because the FIFO was full.

Function
REQ-015 Pixels with sync_x>=640 or sync_y>=480 shall be discarded at stage 1; no write, no overflow.
REQ-016 Stage 1 (cycle n+1 after val at n) shall register per-channel products dvi*(16-ALPHA) and ccd*ALPHA, plus x, y and valid.
REQ-017 Stage 2 (n+2) shall sum the products, shift right by 4 (truncate, no rounding), and compute the address as (y<<9)+(y<<7)+x in 19 bits.
REQ-018 Channel results shall fit 5/6/5 bits without saturation; intermediate sums are 9/10/9 bits.
REQ-019 At the end of n+2 the result shall be pushed into a 4-entry FIFO {addr,data}; wr_req shall assert no earlier than n+3.
REQ-020 Write FSM states: S_IDLE (wr_req=0), S_REQ (wr_req=1, wr_addr/wr_data = FIFO head, held stable).
REQ-021 S_IDLE->S_REQ when the FIFO is non-empty; S_REQ with wr_ack=1 pops the head, then stays in S_REQ if the FIFO is still non-empty, otherwise returns to S_IDLE.
REQ-022 wr_ack while in S_IDLE shall be ignored.
REQ-023 Simultaneous push and pop on a full FIFO shall succeed with no drop.
REQ-024 Push on a full FIFO with no pop shall drop the new pixel and set overflow=1 until reset.
REQ-025 frame_done shall pulse in the cycle after wr_ack pops the entry with address 307199.
REQ-026 val gaps of any length shall be tolerated; back-to-back val every cycle shall sustain one write per cycle while wr_ack is held high.

Reset
REQ-027 Reset shall clear wr_req, wr_addr, wr_data, frame_done, overflow, all pipeline valid bits, FIFO pointers and count, and set the FSM to S_IDLE.
REQ-028 Reset asserted mid-operation shall discard all in-flight and queued pixels with no partial write.
REQ-029 The first val after reset release shall follow the REQ-019 latency exactly.

Configuration
REQ-030 With CHROMA_KEY_EN defined, a pixel whose CCD RGB565 equals KEY_RGB shall be written as the DVI pixel unblended; latency is unchanged.
REQ-031 Without CHROMA_KEY_EN, KEY_RGB is unused and all pixels shall be blended per REQ-017.

Structure
REQ-032 A shared package shall hold FRAME_W=640, FRAME_H=480, ADDR_W=19, the RGB565 pixel typedef, and the FSM state encoding.
REQ-033 The 4-entry FIFO shall be a sub-module named blend_wr_fifo (push, pop, full, empty, count).

Verification
REQ-034 ALPHA=8, val at (2,1) with dvi=16'hFFFF, ccd=16'h0000 -> wr_req at n+3, wr_addr=642, wr_data=16'h7BEF.
REQ-035 val at (640,0) and (0,480) -> no wr_req, overflow stays 0.
REQ-036 wr_ack held 0, six consecutive valid pixels -> four queued, overflow=1; after wr_ack, exactly four writes in order.
REQ-037 Pixel (639,479) with wr_ack=1 -> wr_addr=307199, then a single frame_done pulse.
REQ-038 CHROMA_KEY_EN defined, ccd=16'h07E0, dvi=16'h1234 -> wr_data=16'h1234; undefined -> blended value.
REQ-039 rst_n low while three entries are queued -> wr_req=0 the same cycle, and no stale writes after release.
